// File: rtl/adder_32bit_seq.sv
// Nibble-serial WIDTH-bit adder: one 4-bit slice is reused for NIBBLES clocks,
// least-significant nibble first, with the carry held in a register between nibbles.

module adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       carry_in,
   output logic [3:0] sum,
   output logic       carry_out,
   output logic       overflow
);

   logic [3:0] low;
   logic [1:0] high;

   // Split at bit 3 so the carry into the MSB is visible for signed overflow
   assign low       = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, carry_in};
   assign high      = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, low[3]};
   assign sum       = {high[0], low[2:0]};
   assign carry_out = high[1];
   assign overflow  = high[1] ^ low[3];

endmodule

module adder_32bit_seq #(
   parameter int WIDTH   = 32,
   parameter int NIBBLES = WIDTH / 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int IDXW = $clog2(NIBBLES);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q, state_d;
   logic [IDXW-1:0]  idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] aSh_q, bSh_q, resSh_q, resSh_d;
   logic [WIDTH-1:0] sum_q;
   logic             carryOut_q, overflow_q;

   logic       accept;
   logic [3:0] sliceA, sliceB, sliceSum;
   logic       sliceCin, sliceCout, sliceOvf;
   logic [IDXW+1:0] bitBase;

   assign accept  = start && (state_q != RUN);
   assign bitBase = {idx_q, 2'b00};

   adder_4bit u_slice (
      .a         (sliceA),
      .b         (sliceB),
      .carry_in  (sliceCin),
      .sum       (sliceSum),
      .carry_out (sliceCout),
      .overflow  (sliceOvf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (idx_q == LAST_IDX) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   // Slice is fed zeros outside RUN so it never toggles on idle operands
   always_comb begin
      sliceA   = 4'h0;
      sliceB   = 4'h0;
      sliceCin = 1'b0;
      resSh_d  = resSh_q;
      if (state_q == RUN) begin
         sliceA   = aSh_q[bitBase +: 4];
         sliceB   = bSh_q[bitBase +: 4];
         sliceCin = carry_q;
         resSh_d[bitBase +: 4] = sliceSum;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= '0;
         carry_q    <= 1'b0;
         aSh_q      <= '0;
         bSh_q      <= '0;
         resSh_q    <= '0;
         sum_q      <= '0;
         carryOut_q <= 1'b0;
         overflow_q <= 1'b0;
      end else if (accept) begin
         idx_q   <= '0;
         carry_q <= carry_in;
         aSh_q   <= a;
         bSh_q   <= b;
         resSh_q <= '0;
      end else if (state_q == RUN) begin
         idx_q   <= idx_q + IDXW'(1);
         carry_q <= sliceCout;
         resSh_q <= resSh_d;
         // Visible results only move on the final nibble, never mid-add
         if (idx_q == LAST_IDX) begin
            sum_q      <= resSh_d;
            carryOut_q <= sliceCout;
            overflow_q <= sliceOvf;
         end
      end
   end

   assign sum       = sum_q;
   assign carry_out = carryOut_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_adder_32bit_seq.sv
// Directed bench for adder_32bit_seq: latency, ripple, overflow, ignored start,
// back-to-back start and asynchronous reset mid-operation.

module tb_adder_32bit_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] a, b;
   logic        carry_in;
   logic        busy, done, carry_out, overflow;
   logic [31:0] sum;

   int compared   = 0;
   int mismatched = 0;

   adder_32bit_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [31:0] av,
                                input logic [31:0] bv, input logic cv);
      start    = st;
      a        = av;
      b        = bv;
      carry_in = cv;
   endtask

   // Start one add, then check exact 8-cycle latency and the final result
   task automatic runAdd(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic cv, input logic [31:0] expSum,
                         input logic expCo, input logic expOvf);
      int busyCount;
      applyStimulus(1'b1, av, bv, cv);
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput({tag, "_busy_start"}, 64'(busy), 64'd1);
      busyCount = 1;
      repeat (7) begin
         @(posedge clk); #1;
         if (busy && !done) busyCount++;
      end
      checkOutput({tag, "_busy_cycles"}, 64'(busyCount), 64'd8);
      @(posedge clk); #1;
      checkOutput({tag, "_done"}, 64'(done), 64'd1);
      checkOutput({tag, "_busy_end"}, 64'(busy), 64'd0);
      checkOutput({tag, "_sum"}, 64'(sum), 64'(expSum));
      checkOutput({tag, "_cout"}, 64'(carry_out), 64'(expCo));
      checkOutput({tag, "_ovf"}, 64'(overflow), 64'(expOvf));
   endtask

   initial begin
      int holdOk;
      int doneSeen;

      rst_n = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
      #3;
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_sum", 64'(sum), 64'd0);
      checkOutput("reset_flags", 64'({carry_out, overflow}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      runAdd("one_plus_one", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);
      @(posedge clk); #1;
      checkOutput("done_one_cycle", 64'({done, busy}), 64'd0);

      runAdd("ripple", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
      @(posedge clk); #1;
      runAdd("pos_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
      @(posedge clk); #1;
      runAdd("neg_ovf", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
      @(posedge clk); #1;

      // Start while busy must be ignored and operand changes must not leak in
      applyStimulus(1'b1, 32'h12345678, 32'h11111111, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      applyStimulus(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("ignored_start_busy", 64'(busy), 64'd1);
      repeat (4) begin @(posedge clk); #1; end
      checkOutput("ignored_done", 64'(done), 64'd1);
      checkOutput("ignored_sum", 64'(sum), 64'h23456789);
      checkOutput("ignored_flags", 64'({carry_out, overflow}), 64'd0);

      // Back-to-back start in the done cycle
      applyStimulus(1'b1, 32'h00000005, 32'h0000000A, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("b2b_state", 64'({busy, done}), 64'b10);
      holdOk = 0;
      repeat (7) begin
         @(posedge clk); #1;
         if (sum === 32'h23456789 && !done) holdOk++;
      end
      checkOutput("b2b_sum_hold", 64'(holdOk), 64'd7);
      @(posedge clk); #1;
      checkOutput("b2b_done", 64'(done), 64'd1);
      checkOutput("b2b_sum", 64'(sum), 64'h0000000F);
      @(posedge clk); #1;

      // Asynchronous reset mid-RUN clears outputs before the next edge
      applyStimulus(1'b1, 32'h11111111, 32'h00000001, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_busy_done", 64'({busy, done}), 64'd0);
      checkOutput("arst_sum", 64'(sum), 64'd0);
      checkOutput("arst_flags", 64'({carry_out, overflow}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      doneSeen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done || busy) doneSeen++;
      end
      checkOutput("arst_no_resume", 64'(doneSeen), 64'd0);
      runAdd("after_reset", 32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
